data_sram_like_bridge: RTL

Data-side bridge between the MEM stage's SRAM-style data port and the sram-like bus. It turns each MEM-stage load/store into one sram-like transaction (req/addr_ok/data_ok) and drives `data_stall` into the hazard unit until the transaction completes. It also holds load data stable until the whole pipeline is released, i.e. until `longest_stall` drops. It sits between the MEM stage and the sram-like-to-AXI converter.

---
 rtl/data_sram_like_bridge_if.sv | 54 +++++
 rtl/data_sram_like_bridge.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/data_sram_like_bridge_if.sv
// -----------------------------------------------------------------------------
// data_sram_like_bridge_if
//
// Purpose: sram-like data bus between the data-side bridge (master) and the
// sram-like-to-AXI converter (slave).
//
// Handshake: data_req / data_addr_ok form a req/ack pair. A request is accepted
// in the cycle where both are high, and the request fields must be stable from
// the first cycle data_req rises until that cycle. data_data_ok then pulses for
// one cycle per accepted request, carrying data_rdata for reads and acting as
// the write completion for writes. It has no back-pressure.
//
// Signals:
//   data_req      master -> slave  request valid
//   data_wr       master -> slave  1 = write
//   data_size     master -> slave  0 = byte, 1 = half, 2 = word
//   data_addr     master -> slave  byte address
//   data_wdata    master -> slave  lane-aligned write data
//   data_addr_ok  slave -> master  request accepted
//   data_data_ok  slave -> master  response / write completion
//   data_rdata    slave -> master  response data
// -----------------------------------------------------------------------------
interface data_sram_like_bridge_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req,
        output data_wr,
        output data_size,
        output data_addr,
        output data_wdata,
        input  data_addr_ok,
        input  data_data_ok,
        input  data_rdata
    );

    modport slave (
        input  data_req,
        input  data_wr,
        input  data_size,
        input  data_addr,
        input  data_wdata,
        output data_addr_ok,
        output data_data_ok,
        output data_rdata
    );
endinterface

// File: rtl/data_sram_like_bridge.sv
// -----------------------------------------------------------------------------
// data_sram_like_bridge
//
// Purpose: turns each MEM-stage load/store on the SRAM-style data port into
// exactly one sram-like transaction, and stalls the pipeline until it has
// completed. Load data is captured into a register and held until the next
// completion, so it stays valid for as long as the pipeline is frozen.
//
// Ports:
//   clk              in   core clock
//   resetn           in   synchronous, active-low reset
//   data_sram_en     in   MEM-stage access valid
//   data_sram_wen    in   [3:0] byte write enables, 0 = load
//   data_sram_addr   in   [31:0] byte address
//   data_sram_wdata  in   [31:0] lane-aligned store data
//   data_sram_rdata  out  [31:0] captured load word (registered)
//   flush            in   MEM-stage exception flush
//   longest_stall    in   global pipeline stall (includes data_stall)
//   data_stall       out  stall request to the hazard unit
//   bus              sram-like bus, master side
//   stateDbg         out  [1:0] FSM state: 0 = IDLE, 1 = WAIT, 2 = DONE
// -----------------------------------------------------------------------------
module data_sram_like_bridge (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           data_sram_en,
    input  logic [3:0]                     data_sram_wen,
    input  logic [31:0]                    data_sram_addr,
    input  logic [31:0]                    data_sram_wdata,
    output logic [31:0]                    data_sram_rdata,
    input  logic                           flush,
    input  logic                           longest_stall,
    output logic                           data_stall,
    data_sram_like_bridge_if.master        bus,
    output logic [1:0]                     stateDbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // no transaction outstanding
        WAIT = 2'd1,  // address accepted, waiting for data_ok
        DONE = 2'd2   // result held until the pipeline is released
    } state_t;

    state_t      state;
    state_t      nextState;
    logic [31:0] rdataReg;
    logic        accessWanted;
    logic        isWrite;

    // A flushed instruction must not touch memory, so flush gates the request
    // only before acceptance; after acceptance the transaction always drains.
    assign accessWanted = data_sram_en & ~flush;
    assign isWrite      = |data_sram_wen;

    // -------------------------------------------------------------------------
    // State register and load-data capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            rdataReg <= 32'h0;
        end else begin
            state <= nextState;
            // Captured for writes too; the core ignores it then.
            if (state == WAIT && bus.data_data_ok) begin
                rdataReg <= bus.data_rdata;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (accessWanted && bus.data_addr_ok) begin
                    nextState = WAIT;
                end
            end
            WAIT: begin
                if (bus.data_data_ok) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                // Staying here while the pipeline is frozen is what prevents
                // the same MEM instruction from being issued twice.
                if (!longest_stall) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        bus.data_req = 1'b0;
        data_stall   = 1'b0;
        unique case (state)
            IDLE: begin
                bus.data_req = accessWanted;
                data_stall   = accessWanted;
            end
            WAIT: begin
                data_stall   = 1'b1;
            end
            DONE: begin
                data_stall   = 1'b0;
            end
            default: begin
                bus.data_req = 1'b0;
                data_stall   = 1'b0;
            end
        endcase
        // Reset is synchronous for state, but the handshake outputs must be
        // quiet for the whole time resetn is low.
        if (!resetn) begin
            bus.data_req = 1'b0;
            data_stall   = 1'b0;
        end
    end

    // Request fields follow the MEM-stage inputs directly; MEM is frozen by
    // data_stall while the request waits, so they stay stable.
    always_comb begin
        bus.data_wr    = isWrite;
        bus.data_wdata = data_sram_wdata;
        bus.data_size  = 2'd2;
        bus.data_addr  = data_sram_addr;
        if (isWrite) begin
            unique case (data_sram_wen)
                4'b0001, 4'b0010, 4'b0100, 4'b1000: bus.data_size = 2'd0;
                4'b0011, 4'b1100:                   bus.data_size = 2'd1;
                default:                            bus.data_size = 2'd2;
            endcase
        end else begin
            // Loads fetch the whole word; the core picks out bytes/halves.
            bus.data_addr = {data_sram_addr[31:2], 2'b00};
        end
    end

    assign data_sram_rdata = rdataReg;
    assign stateDbg        = state;

endmodule
